// File: rtl/a_operand_fifo_if.sv
// Handshake bundle between an A-operand producer/consumer and a_operand_fifo.
interface a_operand_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                         i_clr;
    logic                         i_wren;
    logic [DATA_WIDTH-1:0]        i_wdata;
    logic                         o_full;
    logic                         o_afull;
    logic                         i_rden;
    logic [DATA_WIDTH-1:0]        o_rdata;
    logic                         o_empty;
    logic [$clog2(DEPTH+1)-1:0]   o_count;
    logic                         o_overflow;
    logic                         o_underflow;

    modport slave (
        input  i_clr, i_wren, i_wdata, i_rden,
        output o_full, o_afull, o_rdata, o_empty, o_count, o_overflow, o_underflow
    );

    modport master (
        output i_clr, i_wren, i_wdata, i_rden,
        input  o_full, o_afull, o_rdata, o_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/a_operand_fifo.sv
// First-word-fall-through A-operand FIFO feeding vector_reduce; counter-tracked
// occupancy with registered status and sticky overflow/underflow flags.
module a_operand_fifo #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    a_operand_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full;
    logic                  afull;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;
    logic                  flush;
    logic                  rd_acc;
    logic                  wr_acc;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    always_comb begin
        flush     = i_rst | bus.i_clr;
        rd_acc    = bus.i_rden & ~empty;
        wr_acc    = bus.i_wren & (~full | rd_acc);
        count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    end

    always_ff @(posedge i_clk) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            afull     <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            afull <= (count_nxt >= CW'(AFULL_THRESH));
            empty <= (count_nxt == '0);
            if (bus.i_wren && full && !rd_acc) overflow  <= 1'b1;
            if (bus.i_rden && empty)            underflow <= 1'b1;
        end
    end

    // Storage needs no reset; a flush cycle must still drop its write.
    always_ff @(posedge i_clk) begin
        if (wr_acc && !flush) mem[wr_ptr] <= bus.i_wdata;
    end

    always_comb begin
        bus.o_rdata     = empty ? '0 : mem[rd_ptr];
        bus.o_full      = full;
        bus.o_afull     = afull;
        bus.o_empty     = empty;
        bus.o_count     = count;
        bus.o_overflow  = overflow;
        bus.o_underflow = underflow;
    end
endmodule
